// File: rtl/conv1x1_ctrl_pkg.sv
// Shared definitions for the 1x1 convolution layer controller: state encoding,
// datapath word width and the width helper used to size every index.
package conv1x1_ctrl_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_K,
        K_WAIT,
        RUN,
        OC_DRAIN,
        FLUSH,
        DONE
    } ctrl_state_e;

    // Index width for a range of n values; never narrower than one bit.
    function automatic int widthOf(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_result_fifo.sv
// Synchronous result buffer holding {data, address} words between the
// convolution datapath and the result sink.
module conv_result_fifo
    import conv1x1_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int WIDTH      = 32,
    localparam int PTR_W     = widthOf(FIFO_DEPTH),
    localparam int CNT_W     = widthOf(FIFO_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wrPtr_q, rdPtr_q;
    logic [CNT_W-1:0] count_q;
    logic             doPush, doPop;

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    // A push into a full buffer is only accepted when a pop frees a slot in the same cycle.
    assign doPop   = pop_i && (count_q != '0);
    assign doPush  = push_i && ((count_q != CNT_W'(FIFO_DEPTH)) || doPop);
    assign data_o  = mem_q[rdPtr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= nextPtr(wrPtr_q);
            if (doPop)  rdPtr_q <= nextPtr(rdPtr_q);
            unique case ({doPush, doPop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/conv1x1_layer_ctrl.sv
// Layer sequencer for a 1x1 convolution: per output channel it loads one kernel
// word, streams every pixel through the datapath and buffers results for the sink.
module conv1x1_layer_ctrl
    import conv1x1_ctrl_pkg::*;
#(
    parameter int IMG_W      = 16,
    parameter int IMG_H      = 16,
    parameter int NUM_OC     = 8,
    parameter int FIFO_DEPTH = 4,
    localparam int NUM_PIX   = IMG_W * IMG_H,
    localparam int PIX_W     = widthOf(NUM_PIX),
    localparam int OC_W      = widthOf(NUM_OC),
    localparam int ADDR_W    = widthOf(NUM_OC * NUM_PIX),
    localparam int CNT_W     = widthOf(FIFO_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              fm_rd_en,
    output logic [PIX_W-1:0]  fm_rd_addr,
    input  logic [DATA_W-1:0] fm_rd_data,
    output logic              k_rd_en,
    output logic [OC_W-1:0]   k_rd_addr,
    input  logic [DATA_W-1:0] k_rd_data,
    output logic [DATA_W-1:0] conv_data_in,
    output logic [DATA_W-1:0] conv_kernel,
    output logic              conv_valid_in,
    input  logic [DATA_W-1:0] conv_data_out,
    input  logic              conv_valid_out,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic              wr_ready
);

    ctrl_state_e state_q, state_d;
    logic [OC_W-1:0]          oc_q, oc_d;
    logic [PIX_W-1:0]         p_q, p_d;
    logic [DATA_W-1:0]        kernel_q, kernel_d;
    logic [ADDR_W-1:0]        outAddr_q;
    logic [CNT_W-1:0]         inflight_q;
    logic                     validIn_q;
    logic                     clearAddr;
    logic                     issueOk;
    logic                     acceptValid;
    logic [CNT_W-1:0]         fifoCount;
    logic                     fifoEmpty;
    logic [DATA_W+ADDR_W-1:0] fifoHead;

    // Credit check: every outstanding read already owns a buffer slot, so the FIFO cannot overflow.
    assign issueOk     = ({1'b0, inflight_q} + {1'b0, fifoCount}) < (CNT_W + 1)'(FIFO_DEPTH);
    assign acceptValid = conv_valid_out && (inflight_q != '0);

    always_comb begin
        state_d   = state_q;
        oc_d      = oc_q;
        p_d       = p_q;
        kernel_d  = kernel_q;
        fm_rd_en  = 1'b0;
        k_rd_en   = 1'b0;
        done      = 1'b0;
        clearAddr = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    oc_d      = '0;
                    clearAddr = 1'b1;
                    state_d   = LOAD_K;
                end
            end
            LOAD_K: begin
                k_rd_en = 1'b1;
                state_d = K_WAIT;
            end
            K_WAIT: begin
                kernel_d = k_rd_data;
                p_d      = '0;
                state_d  = RUN;
            end
            RUN: begin
                if (issueOk) begin
                    fm_rd_en = 1'b1;
                    p_d      = p_q + 1'b1;
                    if (p_q == PIX_W'(NUM_PIX - 1)) state_d = OC_DRAIN;
                end
            end
            OC_DRAIN: begin
                if (inflight_q == '0) begin
                    if (oc_q != OC_W'(NUM_OC - 1)) begin
                        oc_d    = oc_q + 1'b1;
                        state_d = LOAD_K;
                    end else begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (fifoCount == '0) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            oc_q       <= '0;
            p_q        <= '0;
            kernel_q   <= '0;
            outAddr_q  <= '0;
            inflight_q <= '0;
            validIn_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            oc_q      <= oc_d;
            p_q       <= p_d;
            kernel_q  <= kernel_d;
            validIn_q <= fm_rd_en;
            if (clearAddr)        outAddr_q <= '0;
            else if (acceptValid) outAddr_q <= outAddr_q + 1'b1;
            unique case ({fm_rd_en, acceptValid})
                2'b10:   inflight_q <= inflight_q + 1'b1;
                2'b01:   inflight_q <= inflight_q - 1'b1;
                default: inflight_q <= inflight_q;
            endcase
        end
    end

    conv_result_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (DATA_W + ADDR_W)
    ) u_result_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (acceptValid),
        .pop_i   (wr_en && wr_ready),
        .data_i  ({conv_data_out, outAddr_q}),
        .data_o  (fifoHead),
        .count_o (fifoCount),
        .empty_o (fifoEmpty)
    );

    // Data-carrying outputs are gated by their valids so everything reads zero during reset.
    assign busy          = (state_q != IDLE);
    assign fm_rd_addr    = p_q;
    assign k_rd_addr     = oc_q;
    assign conv_valid_in = validIn_q;
    assign conv_data_in  = validIn_q ? fm_rd_data : '0;
    assign conv_kernel   = kernel_q;
    assign wr_en         = !fifoEmpty;
    assign {wr_data, wr_addr} = wr_en ? fifoHead : '0;

endmodule

// File: tb/tb_conv1x1_layer_ctrl.sv
// Directed bench for conv1x1_layer_ctrl on a 2x2 image with two output channels,
// using behavioural feature-map/kernel memories and a 1- or 3-cycle multiplier model.
module tb_conv1x1_layer_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy, done;
    logic        fm_rd_en;
    logic [1:0]  fm_rd_addr;
    logic [31:0] fm_rd_data = '0;
    logic        k_rd_en;
    logic [0:0]  k_rd_addr;
    logic [31:0] k_rd_data = '0;
    logic [31:0] conv_data_in, conv_kernel;
    logic        conv_valid_in;
    logic [31:0] conv_data_out;
    logic        conv_valid_out;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wr_ready = 1'b1;

    int testsRun = 0;
    int testsFailed = 0;
    int dpLatency = 1;

    logic [31:0] fmMem [4];
    logic [31:0] kMem [2];
    logic        vPipe [3];
    logic [31:0] dPipe [3];

    int          wrTotal = 0;
    int          doneTotal = 0;
    int          fmIssueTotal = 0;
    int          tbInflight = 0;
    int          maxInflight = 0;
    logic [2:0]  wrAddrLog [64];
    logic [31:0] wrDataLog [64];

    always #5 clk = ~clk;

    conv1x1_layer_ctrl #(
        .IMG_W      (2),
        .IMG_H      (2),
        .NUM_OC     (2),
        .FIFO_DEPTH (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .fm_rd_en       (fm_rd_en),
        .fm_rd_addr     (fm_rd_addr),
        .fm_rd_data     (fm_rd_data),
        .k_rd_en        (k_rd_en),
        .k_rd_addr      (k_rd_addr),
        .k_rd_data      (k_rd_data),
        .conv_data_in   (conv_data_in),
        .conv_kernel    (conv_kernel),
        .conv_valid_in  (conv_valid_in),
        .conv_data_out  (conv_data_out),
        .conv_valid_out (conv_valid_out),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_ready       (wr_ready)
    );

    // Memories answer one cycle after the request; the datapath multiplies with configurable latency.
    always @(posedge clk) begin
        if (fm_rd_en) fm_rd_data <= fmMem[fm_rd_addr];
        if (k_rd_en)  k_rd_data  <= kMem[k_rd_addr];
        vPipe[0] <= conv_valid_in;
        dPipe[0] <= conv_data_in * conv_kernel;
        vPipe[1] <= vPipe[0];
        dPipe[1] <= dPipe[0];
        vPipe[2] <= vPipe[1];
        dPipe[2] <= dPipe[1];
    end

    assign conv_valid_out = (dpLatency == 3) ? vPipe[2] : vPipe[0];
    assign conv_data_out  = (dpLatency == 3) ? dPipe[2] : dPipe[0];

    always @(negedge clk) begin
        if (rst) begin
            tbInflight <= 0;
        end else begin
            if (wr_en && wr_ready && wrTotal < 64) begin
                wrAddrLog[wrTotal] <= wr_addr;
                wrDataLog[wrTotal] <= wr_data;
                wrTotal <= wrTotal + 1;
            end
            if (done)     doneTotal <= doneTotal + 1;
            if (fm_rd_en) fmIssueTotal <= fmIssueTotal + 1;
            tbInflight <= tbInflight + (fm_rd_en ? 1 : 0)
                          - ((conv_valid_out && tbInflight > 0) ? 1 : 0);
            maxInflight <= (tbInflight > maxInflight) ? tbInflight : maxInflight;
        end
    end

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic waitDone(input int prevDone, input int limit);
        int cycles = 0;
        while (doneTotal == prevDone && cycles < limit) begin
            tick(1);
            cycles++;
        end
        checkOutput("done_seen", 128'(doneTotal != prevDone), 128'(1));
    endtask

    // Expected layer: fm = {5,7,11,13}, kernels {2,3}; address a holds fm[a%4]*k[a/4].
    task automatic checkLayer(input string tag, input int base);
        logic [31:0] expData [8];
        expData = '{32'd10, 32'd14, 32'd22, 32'd26, 32'd15, 32'd21, 32'd33, 32'd39};
        checkOutput({tag, "_write_count"}, 128'(wrTotal - base), 128'(8));
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("%s_addr%0d", tag, i), 128'(wrAddrLog[base + i]), 128'(i));
            checkOutput($sformatf("%s_data%0d", tag, i), 128'(wrDataLog[base + i]), 128'(expData[i]));
        end
    endtask

    initial begin
        int wrBase, doneBase, fmBase;
        bit found;
        fmMem = '{32'd5, 32'd7, 32'd11, 32'd13};
        kMem  = '{32'd2, 32'd3};
        vPipe = '{1'b0, 1'b0, 1'b0};
        dPipe = '{32'd0, 32'd0, 32'd0};

        @(posedge clk);
        #1;
        checkOutput("reset_outputs_zero",
                    {busy, done, fm_rd_en, fm_rd_addr, k_rd_en, k_rd_addr, conv_data_in,
                     conv_kernel, conv_valid_in, wr_en, wr_addr, wr_data}, '0);
        rst = 1'b0;
        tick(2);
        checkOutput("idle_busy", 128'(busy), 128'(0));

        $display("[TB] basic layer, 1-cycle datapath");
        wrBase = wrTotal;
        doneBase = doneTotal;
        applyStimulus();
        waitDone(doneBase, 200);
        tick(5);
        checkLayer("basic", wrBase);
        checkOutput("basic_done_once", 128'(doneTotal - doneBase), 128'(1));
        checkOutput("basic_busy_after", 128'(busy), 128'(0));

        $display("[TB] sink stalled, start pulsed while busy");
        wr_ready = 1'b0;
        wrBase = wrTotal;
        doneBase = doneTotal;
        fmBase = fmIssueTotal;
        applyStimulus();
        tick(8);
        applyStimulus();
        tick(10);
        checkOutput("stall_issue_count", 128'(fmIssueTotal - fmBase), 128'(4));
        checkOutput("stall_fm_rd_en", 128'(fm_rd_en), 128'(0));
        checkOutput("stall_no_writes", 128'(wrTotal - wrBase), 128'(0));
        checkOutput("stall_wr_en", 128'(wr_en), 128'(1));
        checkOutput("stall_head_addr", 128'(wr_addr), 128'(0));
        checkOutput("stall_head_data", 128'(wr_data), 128'(10));
        checkOutput("stall_busy", 128'(busy), 128'(1));
        wr_ready = 1'b1;
        waitDone(doneBase, 200);
        tick(10);
        checkLayer("stall", wrBase);
        checkOutput("stall_done_once", 128'(doneTotal - doneBase), 128'(1));
        checkOutput("stall_busy_after", 128'(busy), 128'(0));

        $display("[TB] reset in RUN at p=2");
        doneBase = doneTotal;
        applyStimulus();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (fm_rd_en && fm_rd_addr == 2'd2) found = 1'b1;
            else tick(1);
        end
        checkOutput("reached_p2", 128'(found), 128'(1));
        wrBase = wrTotal;
        rst = 1'b1;
        #1;
        checkOutput("midrst_outputs_zero",
                    {busy, done, fm_rd_en, fm_rd_addr, k_rd_en, k_rd_addr, conv_data_in,
                     conv_kernel, conv_valid_in, wr_en, wr_addr, wr_data}, '0);
        tick(1);
        rst = 1'b0;
        tick(10);
        checkOutput("midrst_no_done", 128'(doneTotal - doneBase), 128'(0));
        checkOutput("midrst_no_writes", 128'(wrTotal - wrBase), 128'(0));
        checkOutput("midrst_idle", 128'(busy), 128'(0));
        wrBase = wrTotal;
        applyStimulus();
        waitDone(doneBase, 200);
        tick(5);
        checkLayer("after_rst", wrBase);

        $display("[TB] 3-cycle datapath");
        dpLatency = 3;
        tick(2);
        wrBase = wrTotal;
        doneBase = doneTotal;
        applyStimulus();
        waitDone(doneBase, 300);
        tick(5);
        checkLayer("lat3", wrBase);
        checkOutput("lat3_done_once", 128'(doneTotal - doneBase), 128'(1));
        checkOutput("max_inflight_le4", 128'(maxInflight <= 4), 128'(1));

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
